// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP pattern transmitter.
// Holds FSM states, pattern encodings, colour-bar palette and line timing.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_SOLID,
        PAT_BARS,
        PAT_GRAD,
        PAT_CHECK
    } pat_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Position of the byte about to be driven on the bus.
    typedef struct packed {
        logic       href;
        logic       ph;
        logic [9:0] x;
        logic [9:0] y;
    } pix_pos_t;

    function automatic int line_t(int h_active, int h_blank);
        return 2 * h_active + h_blank;
    endfunction

    function automatic logic [15:0] bar_color(logic [2:0] idx);
        logic [15:0] c;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_tx_if.sv
// Camera-side parallel pixel bus (OV7670 DVP).
// master drives the bus, slave is the capture end.
interface dvp_tx_if;
    logic       cmos_pclk;
    logic       cmos_vsync;
    logic       cmos_href;
    logic [7:0] cmos_db;

    modport master (
        output cmos_pclk,
        output cmos_vsync,
        output cmos_href,
        output cmos_db
    );

    modport slave (
        input cmos_pclk,
        input cmos_vsync,
        input cmos_href,
        input cmos_db
    );
endinterface

// File: rtl/dvp_tx_timing.sv
// Pclk divider, tick/line counters and frame state machine.
// Everything advances in the clk cycle where pclk falls.
module dvp_tx_timing
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     enable_i,
    output logic     pclk_o,
    output logic     vsync_o,
    output logic     href_o,
    output logic     busy_o,
    output logic     fall_o,
    output logic     start_o,
    output logic     done_o,
    output pix_pos_t nxt_o
);

    localparam int LINE_T = line_t(H_ACTIVE, H_BLANK);
    localparam int HALF   = PCLK_DIV / 2;

    logic [7:0]  div_q;
    logic        pclk_q;
    logic        tog;
    logic        fall;
    state_t      st_q, st_d, st_nx;
    logic [15:0] h_q, h_d;
    logic [15:0] l_q, l_d;
    logic [15:0] nlines;
    logic        vs_q, hr_q, busy_q;
    logic        start, done;
    pix_pos_t    nxt;

    assign tog  = (div_q == 8'(HALF - 1));
    assign fall = tog && pclk_q;

    always_comb begin
        nlines = 16'(V_FRONT);
        st_nx  = IDLE;
        case (st_q)
            VSYNC: begin
                nlines = 16'(VSYNC_LINES);
                st_nx  = VBACK;
            end
            VBACK: begin
                nlines = 16'(V_BACK);
                st_nx  = ACTIVE;
            end
            ACTIVE: begin
                nlines = 16'(V_ACTIVE);
                st_nx  = VFRONT;
            end
            default: ;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        h_d   = h_q;
        l_d   = l_q;
        start = 1'b0;
        done  = 1'b0;
        if (fall) begin
            if (st_q == IDLE) begin
                if (enable_i) begin
                    st_d  = VSYNC;
                    h_d   = '0;
                    l_d   = '0;
                    start = 1'b1;
                end
            end else begin
                h_d = h_q + 16'd1;
                if (h_q == 16'(LINE_T - 1)) begin
                    h_d = '0;
                    l_d = l_q + 16'd1;
                    if (l_q == nlines - 16'd1) begin
                        l_d  = '0;
                        st_d = st_nx;
                        // Frame end re-checks enable so frames abut.
                        if (st_q == VFRONT) begin
                            done  = 1'b1;
                            start = enable_i;
                            st_d  = enable_i ? VSYNC : IDLE;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        nxt.href = (st_d == ACTIVE) && (h_d < 16'(2 * H_ACTIVE));
        nxt.ph   = h_d[0];
        nxt.x    = h_d[10:1];
        nxt.y    = l_d[9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
            st_q   <= IDLE;
            h_q    <= '0;
            l_q    <= '0;
            vs_q   <= 1'b0;
            hr_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            div_q <= tog ? 8'd0 : div_q + 8'd1;
            if (tog) begin
                pclk_q <= ~pclk_q;
            end
            st_q   <= st_d;
            h_q    <= h_d;
            l_q    <= l_d;
            vs_q   <= (st_d == VSYNC);
            hr_q   <= nxt.href;
            busy_q <= (st_d != IDLE);
        end
    end

    assign pclk_o  = pclk_q;
    assign vsync_o = vs_q;
    assign href_o  = hr_q;
    assign busy_o  = busy_q;
    assign fall_o  = fall;
    assign start_o = start;
    assign done_o  = done;
    assign nxt_o   = nxt;

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP test-pattern source, RGB565 high byte first.
// Define DVP_TX_PCLK_GATE_EN to stop pclk outside active-pixel ticks.
module dvp_pattern_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    dvp_tx_if.master    dvp,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic        pclk, vsync, href, fall, start, done;
    pix_pos_t    nxt;
    pat_t        pat_q;
    logic [15:0] solid_q;
    logic [2:0]  bar_q, bar_d;
    logic [9:0]  bw_q, bw_d;
    logic [7:0]  db_q, db_d;
    logic        fdone_q;
    logic [15:0] fcnt_q;
    logic [15:0] pix;

    dvp_tx_timing #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .H_BLANK    (H_BLANK),
        .VSYNC_LINES(VSYNC_LINES),
        .V_BACK     (V_BACK),
        .V_FRONT    (V_FRONT),
        .PCLK_DIV   (PCLK_DIV)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable_i(enable),
        .pclk_o  (pclk),
        .vsync_o (vsync),
        .href_o  (href),
        .busy_o  (busy),
        .fall_o  (fall),
        .start_o (start),
        .done_o  (done),
        .nxt_o   (nxt)
    );

    // Bar index counts pixel widths and sticks at the last bar.
    always_comb begin
        bar_d = bar_q;
        bw_d  = bw_q;
        if (fall) begin
            if (!nxt.href || !href) begin
                bar_d = '0;
                bw_d  = '0;
            end else if (!nxt.ph) begin
                if (bw_q == 10'(BAR_W - 1)) begin
                    bw_d = '0;
                    if (bar_q != 3'd7) begin
                        bar_d = bar_q + 3'd1;
                    end
                end else begin
                    bw_d = bw_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        unique case (pat_q)
            PAT_SOLID: pix = solid_q;
            PAT_BARS:  pix = bar_color(bar_d);
            PAT_GRAD:  pix = {nxt.x[9:5], nxt.x[9:4], nxt.x[9:5]};
            PAT_CHECK: pix = (nxt.x[5] ^ nxt.y[5]) ? 16'hFFFF : 16'h0000;
            default:   pix = 16'h0000;
        endcase
        db_d = nxt.href ? (nxt.ph ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= PAT_SOLID;
            solid_q <= '0;
            bar_q   <= '0;
            bw_q    <= '0;
            db_q    <= '0;
            fdone_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            if (start) begin
                pat_q   <= pat_t'(pattern_sel);
                solid_q <= solid_color;
            end
            bar_q   <= bar_d;
            bw_q    <= bw_d;
            if (fall) begin
                db_q <= db_d;
            end
            fdone_q <= done;
            if (done) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

`ifdef DVP_TX_PCLK_GATE_EN
    assign dvp.cmos_pclk = pclk & href;
`else
    assign dvp.cmos_pclk = pclk;
`endif
    assign dvp.cmos_vsync = vsync;
    assign dvp.cmos_href  = href;
    assign dvp.cmos_db    = db_q;
    assign frame_done     = fdone_q;
    assign frame_cnt      = fcnt_q;

endmodule
